dccm_banked: RTL and testbench
==============================

Name: dccm_banked

Overview:
- Parametrised successor of the single-port data memory: word-interleaved multi-bank data memory with NUM_RD_PORTS independent read ports and one byte-enabled write port.
- Read ports carry tags end-to-end.
- Read latency is configurable.
- Bank conflicts between read ports are resolved by round-robin arbitration.
- Sits between the EXU load/store path (and future ports such as a debug or DMA reader) and the storage array.

Parameters:
XLEN, 32, data word width in bits (multiple of 8)
DEPTH, 4096, total words across all banks (power of two, multiple of NUM_BANKS)
NUM_BANKS, 4, number of word-interleaved banks (power of two, >=1)
NUM_RD_PORTS, 2, number of read ports (>=1)
RD_LATENCY, 1, cycles from read accept to response (1..4)
TAG_WIDTH, 4, read tag width
INIT_FILE, "", hex init file for $readmemh at time 0; empty = no init

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rd_valid  in  NUM_RD_PORTS  per-port read request
rd_ready  out  NUM_RD_PORTS  per-port grant; request accepted when valid&ready
rd_addr  in  NUM_RD_PORTS*XLEN  per-port byte address; bits [1:0] ignored
rd_tag  in  NUM_RD_PORTS*TAG_WIDTH  per-port request tag
rsp_valid  out  NUM_RD_PORTS  per-port response valid (one-cycle pulse)
rsp_data  out  NUM_RD_PORTS*XLEN  per-port read data
rsp_tag  out  NUM_RD_PORTS*TAG_WIDTH  per-port tag echoed from accepted request
wr_valid  in  1  write request; always accepted
wr_addr  in  XLEN  write byte address; bits [1:0] ignored
wr_be  in  XLEN/8  byte enables
wr_data  in  XLEN  write data

Behaviour:
- Address decode:
  - word = addr[log2(DEPTH)+1:2]; upper bits ignored, so addresses wrap modulo DEPTH words.
  - bank = word[log2(NUM_BANKS)-1:0]; row = word >> log2(NUM_BANKS).
- Each bank has one read port and one write port; writes never stall and never conflict with reads.
- Arbitration (combinational, per bank):
  - Among ports with rd_valid whose bank matches, grant the first port at or after rr_ptr (modulo NUM_RD_PORTS).
  - rd_ready[p] = grant[p]; rd_ready[p] is also 1 when rd_valid[p]=0, so an idle port shows ready.
  - rd_ready depends on rd_valid/rd_addr of all ports. Masters must not make rd_valid depend on rd_ready.
- rr_ptr:
  - Registered; advances by 1 (wraps at NUM_RD_PORTS) in any cycle in which at least one request is denied.
  - Holds otherwise.
  - With NUM_RD_PORTS=1 it is constant 0.
- Denied request: master must hold rd_valid, rd_addr and rd_tag stable until accepted. Starvation is bounded by NUM_RD_PORTS-1 cycles.
- Read pipeline:
  - Request accepted in cycle T produces rsp_valid=1 with data and tag in cycle T+RD_LATENCY.
  - Fully pipelined: one accept per port per cycle. No response backpressure.
  - Responses from different ports are independent; each port's responses come back in its own accept order.
- Write timing:
  - When wr_valid=1, bytes with wr_be[i]=1 update at the clock edge; wr_be=0 is a no-op.
- Same word read and written in the same cycle (write-first forwarding):
  - Response bytes whose wr_be bit is set carry the new wr_data bytes; other bytes carry the old contents.
  - Forwarding applies at accept time only. Writes to that word during the RD_LATENCY-1 pipeline cycles do not alter an in-flight response.
- Reset:
  - rsp_valid=0, rsp_data=0 and rsp_tag=0 on all ports; rr_ptr=0; all pipeline valid bits cleared.
  - Memory contents are not reset.
  - While rst=1: rd_ready=0 on all ports and writes are ignored.
- Reset mid-operation: in-flight responses are discarded, so no rsp_valid after reset deassertion for pre-reset requests.
- Uninitialised locations read as X in simulation; the bench must not check them.

Test Plan:
- Basic write/read, RD_LATENCY=1:
  - Stimulus: write 0xDEADBEEF to 0x100, be=0xF; next cycle port0 reads 0x100, tag=3.
  - Required: one cycle after accept, rsp_valid[0]=1, data=0xDEADBEEF, tag=3.
- Byte enables:
  - Stimulus: 0x200 holds 0x11223344; write 0xAABBCCDD with be=0x5; then read.
  - Required: 0x11BB33DD.
- Conflict and round-robin:
  - Stimulus: ports 0 and 1 both request bank 0 (0x000 and 0x010) for 3 consecutive cycles, rr_ptr=0.
  - Required: cycle 1 grants port0 (rd_ready=2'b01); cycle 2 grants port1; cycle 3 grants port0.
  - Required: no conflict when addresses are 0x000 and 0x004 (rd_ready=2'b11).
- Same-cycle forwarding:
  - Stimulus: 0x300 holds 0x00000000; same cycle write 0xFFFFFFFF be=0x3 and read 0x300.
  - Required: response 0x0000FFFF; a later read returns 0x0000FFFF.
- Latency and pipelining, RD_LATENCY=3:
  - Stimulus: port0 issues back-to-back reads of 0x000, 0x004 and 0x008 with tags 1, 2 and 3.
  - Required: rsp_valid[0] high on 3 consecutive cycles starting T+3, tags 1, 2, 3 in order.
- Reset mid-flight and wrap:
  - Stimulus: assert rst one cycle after accepting a read with RD_LATENCY=3.
  - Required: no rsp_valid follows; outputs are 0 immediately.
  - Stimulus: with DEPTH=4096, read address 0x4000 after writing 0x0.
  - Required: returns the data at 0x0.

Source files
------------

// File: rtl/dccm_banked.sv
// dccm_banked: word-interleaved, multi-bank data memory.
//
// NUM_BANKS word-interleaved banks, NUM_RD_PORTS tagged read ports and one
// byte-enabled write port. When read ports collide on a bank, a round-robin
// arbiter picks the winner. Reads have a fixed latency of RD_LATENCY cycles
// and are fully pipelined. A write and a read to the same word in the same
// cycle forward the written bytes to the read.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   rd_valid/ready  per-port request handshake; ready is combinational
//   rd_addr/rd_tag  per-port byte address (bits [1:0] ignored) and tag
//   rsp_valid       per-port one-cycle response pulse
//   rsp_data/tag    per-port read data and echoed tag
//   wr_valid        write request; always accepted
//   wr_addr/be/data write byte address, byte enables, data
module dccm_banked #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH        = 4096,
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned TAG_WIDTH    = 4,
  parameter string       INIT_FILE    = ""
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_RD_PORTS-1:0]           rd_valid,
  output logic [NUM_RD_PORTS-1:0]           rd_ready,
  input  logic [NUM_RD_PORTS*XLEN-1:0]      rd_addr,
  input  logic [NUM_RD_PORTS*TAG_WIDTH-1:0] rd_tag,
  output logic [NUM_RD_PORTS-1:0]           rsp_valid,
  output logic [NUM_RD_PORTS*XLEN-1:0]      rsp_data,
  output logic [NUM_RD_PORTS*TAG_WIDTH-1:0] rsp_tag,
  input  logic                              wr_valid,
  input  logic [XLEN-1:0]                   wr_addr,
  input  logic [XLEN/8-1:0]                 wr_be,
  input  logic [XLEN-1:0]                   wr_data
);

  localparam int unsigned WordW    = $clog2(DEPTH);
  localparam int unsigned BankW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned PtrW     = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1;
  localparam int unsigned NumBytes = XLEN / 8;

  // Storage: flat array indexed by word; the low word bits select the bank,
  // so mem[word] is bank (word % NUM_BANKS), row (word / NUM_BANKS).
  logic [XLEN-1:0] mem [DEPTH];

  // Address bits above the word index and below the word offset are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr, wr_addr};

  //--------------------------------------------------------------------------
  // Address decode
  //--------------------------------------------------------------------------
  logic [WordW-1:0] rd_word [NUM_RD_PORTS];
  logic [BankW-1:0] rd_bank [NUM_RD_PORTS];
  logic [WordW-1:0] wr_word;

  always_comb begin
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      rd_word[p] = rd_addr[p*XLEN+2 +: WordW];
      rd_bank[p] = (NUM_BANKS > 1) ? rd_word[p][BankW-1:0] : '0;
    end
    wr_word = wr_addr[2 +: WordW];
  end

  //--------------------------------------------------------------------------
  // Round-robin arbitration
  //--------------------------------------------------------------------------
  logic [PtrW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_RD_PORTS-1:0] grant;
  logic [NUM_RD_PORTS-1:0] accept;
  logic                    any_denied;

  // Priority distance of a port from the round-robin pointer; 0 = highest.
  function automatic int unsigned rr_dist(int unsigned port, logic [PtrW-1:0] ptr);
    int unsigned ptr_i;
    ptr_i = 32'(ptr);
    return (port + NUM_RD_PORTS - ptr_i) % NUM_RD_PORTS;
  endfunction

  always_comb begin
    grant = '0;
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      if (rd_valid[p]) begin
        grant[p] = 1'b1;
        // Lose to any valid port on the same bank that is nearer the pointer.
        for (int unsigned q = 0; q < NUM_RD_PORTS; q++) begin
          if (q != p && rd_valid[q] && rd_bank[q] == rd_bank[p] &&
              rr_dist(q, rr_ptr_q) < rr_dist(p, rr_ptr_q)) begin
            grant[p] = 1'b0;
          end
        end
      end
    end
  end

  // Idle ports show ready; the whole handshake is held off during reset.
  // Ready depends on every port's valid/address, so masters must never make
  // rd_valid a function of rd_ready or a combinational loop results.
  always_comb begin
    rd_ready   = rst ? '0 : (grant | ~rd_valid);
    accept     = rst ? '0 : (grant & rd_valid);
    any_denied = |(rd_valid & ~grant);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (!rst && any_denied) begin
      rr_ptr_d = (32'(rr_ptr_q) == NUM_RD_PORTS - 1) ? '0 : rr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  //--------------------------------------------------------------------------
  // Bank read ports and write-first forwarding
  //--------------------------------------------------------------------------
  logic [WordW-1:0] bank_raddr [NUM_BANKS];
  logic [XLEN-1:0]  bank_rdata [NUM_BANKS];
  logic [XLEN-1:0]  rd_fwd     [NUM_RD_PORTS];

  // Each bank serves at most one granted port per cycle.
  always_comb begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_raddr[b] = '0;
      for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
        if (grant[p] && rd_bank[p] == BankW'(b)) begin
          bank_raddr[b] = rd_word[p];
        end
      end
      bank_rdata[b] = mem[bank_raddr[b]];
    end
  end

  // Bytes written in the accept cycle replace the stored bytes in the response.
  always_comb begin
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      rd_fwd[p] = bank_rdata[rd_bank[p]];
      if (wr_valid && wr_word == rd_word[p]) begin
        for (int unsigned i = 0; i < NumBytes; i++) begin
          if (wr_be[i]) begin
            rd_fwd[p][8*i +: 8] = wr_data[8*i +: 8];
          end
        end
      end
    end
  end

  //--------------------------------------------------------------------------
  // Write port (writes are dropped while reset is held)
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && wr_valid) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (wr_be[i]) begin
          mem[wr_word][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  //--------------------------------------------------------------------------
  // Read response pipeline, one shift register per port
  //--------------------------------------------------------------------------
  logic [RD_LATENCY-1:0] pipe_vld_q  [NUM_RD_PORTS];
  logic [RD_LATENCY-1:0] pipe_vld_d  [NUM_RD_PORTS];
  logic [XLEN-1:0]       pipe_data_q [NUM_RD_PORTS][RD_LATENCY];
  logic [XLEN-1:0]       pipe_data_d [NUM_RD_PORTS][RD_LATENCY];
  logic [TAG_WIDTH-1:0]  pipe_tag_q  [NUM_RD_PORTS][RD_LATENCY];
  logic [TAG_WIDTH-1:0]  pipe_tag_d  [NUM_RD_PORTS][RD_LATENCY];

  // Data and tag are zeroed for empty slots so idle outputs stay at 0.
  always_comb begin
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      pipe_vld_d[p]     = '0;
      pipe_vld_d[p][0]  = accept[p];
      pipe_data_d[p][0] = accept[p] ? rd_fwd[p] : '0;
      pipe_tag_d[p][0]  = accept[p] ? rd_tag[p*TAG_WIDTH +: TAG_WIDTH] : '0;
      for (int unsigned s = 1; s < RD_LATENCY; s++) begin
        pipe_vld_d[p][s]  = pipe_vld_q[p][s-1];
        pipe_data_d[p][s] = pipe_data_q[p][s-1];
        pipe_tag_d[p][s]  = pipe_tag_q[p][s-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
        pipe_vld_q[p] <= '0;
        for (int unsigned s = 0; s < RD_LATENCY; s++) begin
          pipe_data_q[p][s] <= '0;
          pipe_tag_q[p][s]  <= '0;
        end
      end
    end else begin
      for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
        pipe_vld_q[p] <= pipe_vld_d[p];
        for (int unsigned s = 0; s < RD_LATENCY; s++) begin
          pipe_data_q[p][s] <= pipe_data_d[p][s];
          pipe_tag_q[p][s]  <= pipe_tag_d[p][s];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
      rsp_valid[p]                          = pipe_vld_q[p][RD_LATENCY-1];
      rsp_data[p*XLEN +: XLEN]              = pipe_data_q[p][RD_LATENCY-1];
      rsp_tag[p*TAG_WIDTH +: TAG_WIDTH]     = pipe_tag_q[p][RD_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_dccm_banked.sv
// tb_dccm_banked: directed bench for dccm_banked. Two instances share every
// input: one with RD_LATENCY=1 and one with RD_LATENCY=3.
module tb_dccm_banked;

  logic        clk;
  logic        rst;
  logic [1:0]  rd_valid;
  logic [63:0] rd_addr;
  logic [7:0]  rd_tag;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  logic [1:0]  rd_ready_l1, rsp_valid_l1;
  logic [63:0] rsp_data_l1;
  logic [7:0]  rsp_tag_l1;
  logic [1:0]  rd_ready_l3, rsp_valid_l3;
  logic [63:0] rsp_data_l3;
  logic [7:0]  rsp_tag_l3;

  int n_checks = 0;
  int n_fail   = 0;

  dccm_banked #(.RD_LATENCY(1)) u_dut_l1 (
    .clk      (clk),
    .rst      (rst),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready_l1),
    .rd_addr  (rd_addr),
    .rd_tag   (rd_tag),
    .rsp_valid(rsp_valid_l1),
    .rsp_data (rsp_data_l1),
    .rsp_tag  (rsp_tag_l1),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be),
    .wr_data  (wr_data)
  );

  dccm_banked #(.RD_LATENCY(3)) u_dut_l3 (
    .clk      (clk),
    .rst      (rst),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready_l3),
    .rd_addr  (rd_addr),
    .rd_tag   (rd_tag),
    .rsp_valid(rsp_valid_l3),
    .rsp_data (rsp_data_l3),
    .rsp_tag  (rsp_tag_l3),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be),
    .wr_data  (wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic v, input logic [31:0] a, input logic [3:0] t);
    rd_valid[p]        = v;
    rd_addr[p*32 +: 32] = a;
    rd_tag[p*4 +: 4]    = t;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_be    = be;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    rd_valid = '0;
    rd_addr  = '0;
    rd_tag   = '0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_be    = '0;
    wr_data  = '0;

    // Reset state, including ready held low while reset is asserted.
    rd_valid = 2'b11;
    #2;
    check_eq("rst_rsp_valid", 64'(rsp_valid_l1), 64'h0);
    check_eq("rst_rsp_data", rsp_data_l1, 64'h0);
    check_eq("rst_rsp_tag", 64'(rsp_tag_l1), 64'h0);
    check_eq("rst_rd_ready", 64'(rd_ready_l1), 64'h0);
    tick();
    tick();
    rst      = 1'b0;
    rd_valid = '0;
    #1;
    check_eq("idle_rd_ready", 64'(rd_ready_l1), 64'h3);

    // Basic write then read.
    do_write(32'h100, 4'hF, 32'hDEADBEEF);
    set_rd(0, 1'b1, 32'h100, 4'd3);
    #1;
    check_eq("basic_ready", 64'(rd_ready_l1), 64'h3);
    tick();
    set_rd(0, 1'b0, 32'h0, 4'd0);
    check_eq("basic_valid", 64'(rsp_valid_l1), 64'h1);
    check_eq("basic_data", 64'(rsp_data_l1[31:0]), 64'hDEADBEEF);
    check_eq("basic_tag", 64'(rsp_tag_l1[3:0]), 64'h3);
    tick();
    check_eq("basic_pulse", 64'(rsp_valid_l1), 64'h0);

    // Byte enables, read on port 1.
    do_write(32'h200, 4'hF, 32'h11223344);
    do_write(32'h200, 4'h5, 32'hAABBCCDD);
    set_rd(1, 1'b1, 32'h200, 4'd5);
    tick();
    set_rd(1, 1'b0, 32'h0, 4'd0);
    check_eq("be_valid", 64'(rsp_valid_l1), 64'h2);
    check_eq("be_data", 64'(rsp_data_l1[63:32]), 64'h11BB33DD);
    check_eq("be_tag", 64'(rsp_tag_l1[7:4]), 64'h5);

    // Bank conflict: 0x000 and 0x010 both map to bank 0.
    set_rd(0, 1'b1, 32'h000, 4'd0);
    set_rd(1, 1'b1, 32'h010, 4'd1);
    #1;
    check_eq("rr_cycle1", 64'(rd_ready_l1), 64'h1);
    tick();
    check_eq("rr_cycle1_rsp", 64'(rsp_valid_l1), 64'h1);
    check_eq("rr_cycle2", 64'(rd_ready_l1), 64'h2);
    tick();
    check_eq("rr_cycle2_rsp_tag", 64'(rsp_tag_l1[7:4]), 64'h1);
    check_eq("rr_cycle3", 64'(rd_ready_l1), 64'h1);
    // Different banks never conflict.
    set_rd(1, 1'b1, 32'h004, 4'd1);
    #1;
    check_eq("no_conflict", 64'(rd_ready_l1), 64'h3);
    tick();
    check_eq("no_conflict_rsp", 64'(rsp_valid_l1), 64'h3);
    set_rd(0, 1'b0, 32'h0, 4'd0);
    set_rd(1, 1'b0, 32'h0, 4'd0);

    // Same-cycle write and read of one word.
    do_write(32'h300, 4'hF, 32'h00000000);
    wr_valid = 1'b1;
    wr_addr  = 32'h300;
    wr_be    = 4'h3;
    wr_data  = 32'hFFFFFFFF;
    set_rd(0, 1'b1, 32'h300, 4'd7);
    tick();
    wr_valid = 1'b0;
    check_eq("fwd_data", 64'(rsp_data_l1[31:0]), 64'h0000FFFF);
    tick();
    set_rd(0, 1'b0, 32'h0, 4'd0);
    check_eq("fwd_later_data", 64'(rsp_data_l1[31:0]), 64'h0000FFFF);

    // Latency 3, back-to-back reads on port 0.
    do_write(32'h000, 4'hF, 32'h000000A0);
    do_write(32'h004, 4'hF, 32'h000000A1);
    do_write(32'h008, 4'hF, 32'h000000A2);
    set_rd(0, 1'b1, 32'h000, 4'd1);
    tick();
    check_eq("lat3_t1_valid", 64'(rsp_valid_l3), 64'h0);
    set_rd(0, 1'b1, 32'h004, 4'd2);
    tick();
    check_eq("lat3_t2_valid", 64'(rsp_valid_l3), 64'h0);
    set_rd(0, 1'b1, 32'h008, 4'd3);
    tick();
    set_rd(0, 1'b0, 32'h0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("lat3_valid", 64'(rsp_valid_l3), 64'h1);
      check_eq("lat3_tag", 64'(rsp_tag_l3[3:0]), 64'(i + 1));
      check_eq("lat3_data", 64'(rsp_data_l3[31:0]), 64'(32'hA0 + i));
      tick();
    end
    check_eq("lat3_end", 64'(rsp_valid_l3), 64'h0);

    // Reset one cycle after accepting a read; writes ignored during reset.
    set_rd(0, 1'b1, 32'h000, 4'd9);
    tick();
    set_rd(0, 1'b0, 32'h0, 4'd0);
    check_eq("pre_rst_l1_valid", 64'(rsp_valid_l1), 64'h1);
    check_eq("pre_rst_l1_data", 64'(rsp_data_l1[31:0]), 64'hA0);
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 32'h000;
    wr_be    = 4'hF;
    wr_data  = 32'h55555555;
    #1;
    check_eq("mid_rst_l1_valid", 64'(rsp_valid_l1), 64'h0);
    check_eq("mid_rst_l1_data", rsp_data_l1, 64'h0);
    check_eq("mid_rst_l1_tag", 64'(rsp_tag_l1), 64'h0);
    check_eq("mid_rst_l3_valid", 64'(rsp_valid_l3), 64'h0);
    tick();
    wr_valid = 1'b0;
    rst      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("post_rst_l3_quiet", 64'(rsp_valid_l3), 64'h0);
    end
    set_rd(0, 1'b1, 32'h000, 4'd4);
    tick();
    set_rd(0, 1'b0, 32'h0, 4'd0);
    check_eq("rst_write_ignored", 64'(rsp_data_l1[31:0]), 64'hA0);

    // Address wrap: 0x4000 aliases word 0 with DEPTH=4096.
    do_write(32'h0, 4'hF, 32'h12345678);
    set_rd(1, 1'b1, 32'h4000, 4'd2);
    tick();
    set_rd(1, 1'b0, 32'h0, 4'd0);
    check_eq("wrap_valid", 64'(rsp_valid_l1), 64'h2);
    check_eq("wrap_data", 64'(rsp_data_l1[63:32]), 64'h12345678);
    check_eq("wrap_tag", 64'(rsp_tag_l1[7:4]), 64'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
